rotary_enc_decoder: RTL and testbench

Front-end conditioner for the PmodENC rotary encoder on header JC, upstream of the embedded system's encoder inputs. Synchronizes and debounces the raw A, B, button and slide-switch pins, then decodes the A/B quadrature with a state machine. Outputs are a signed position count, single-cycle step and button-press pulses, and clean switch and button levels. Firmware reads these instead of the bouncing pins.

---
 rtl/enc_pkg.sv | 43 ++++
 rtl/rotary_enc_decoder_if.sv | 38 +++
 rtl/enc_debounce.sv | 43 ++++
 rtl/rotary_enc_decoder.sv | 155 +++++++++++++++
 tb/tb_rotary_enc_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the PmodENC rotary encoder front end:
// quadrature FSM states, Gray codes of the A/B pair and step directions.
package enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CW1,
        ST_CW2,
        ST_CW3,
        ST_CCW1,
        ST_CCW2,
        ST_CCW3,
        ST_IDLE_WAIT
    } quad_state_t;

    localparam logic [1:0] REST    = 2'b11;
    localparam logic [1:0] PH1_CW  = 2'b01;
    localparam logic [1:0] PH_MID  = 2'b00;
    localparam logic [1:0] PH1_CCW = 2'b10;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // A/B code that each state stands for; a two-bit difference from it is illegal
    function automatic logic [1:0] state_code(quad_state_t s);
        case (s)
            ST_IDLE:          return REST;
            ST_CW1, ST_CCW3:  return PH1_CW;
            ST_CW3, ST_CCW1:  return PH1_CCW;
            default:          return PH_MID;
        endcase
    endfunction

    function automatic quad_state_t fresh_state(logic [1:0] code);
        case (code)
            REST:    return ST_IDLE;
            PH1_CW:  return ST_CW1;
            PH1_CCW: return ST_CCW1;
            default: return ST_IDLE_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/rotary_enc_decoder_if.sv
// Pin and result bundle between the encoder header and the decoder.
// The velocity signal exists only when ENC_VELOCITY_EN is defined.
interface rotary_enc_decoder_if #(
    parameter int POS_W = 16
);
    logic                    encA;
    logic                    encB;
    logic                    encBTN;
    logic                    encSWT;
    logic                    pos_clear;
    logic signed [POS_W-1:0] position;
    logic                    step_pulse;
    logic                    step_dir;
    logic                    btn_level;
    logic                    swt_level;
    logic                    btn_pulse;
    logic                    quad_err;
`ifdef ENC_VELOCITY_EN
    logic signed [POS_W-1:0] velocity;
`endif

    modport master (
        output encA, encB, encBTN, encSWT, pos_clear,
        input  position, step_pulse, step_dir, btn_level, swt_level, btn_pulse, quad_err
`ifdef ENC_VELOCITY_EN
        , input velocity
`endif
    );

    modport slave (
        input  encA, encB, encBTN, encSWT, pos_clear,
        output position, step_pulse, step_dir, btn_level, swt_level, btn_pulse, quad_err
`ifdef ENC_VELOCITY_EN
        , output velocity
`endif
    );

endinterface

// File: rtl/enc_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level
// only follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module enc_debounce #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= RESET_LEVEL;
            sync2   <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt     <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level_q) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rotary_enc_decoder.sv
// PmodENC front end: debounced pins, quadrature FSM, position counter and
// button edge pulse. ENC_VELOCITY_EN adds the windowed velocity measurement.
module rotary_enc_decoder
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int POS_W           = 16
`ifdef ENC_VELOCITY_EN
    , parameter int VEL_WINDOW    = 10_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    rotary_enc_decoder_if.slave  bus
);
    logic deb_a, deb_b, deb_btn, deb_swt;

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_deb_a (
        .clk(clk), .reset(reset), .raw(bus.encA), .level(deb_a));
    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_deb_b (
        .clk(clk), .reset(reset), .raw(bus.encB), .level(deb_b));
    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_deb_btn (
        .clk(clk), .reset(reset), .raw(bus.encBTN), .level(deb_btn));
    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_deb_swt (
        .clk(clk), .reset(reset), .raw(bus.encSWT), .level(deb_swt));

    quad_state_t             state, state_next;
    logic [1:0]              ab;
    logic                    step_cw, step_ccw, err;
    logic signed [POS_W-1:0] pos_q;
    logic                    step_pulse_q, step_dir_q, btn_prev, btn_pulse_q, quad_err_q;

    assign ab = {deb_a, deb_b};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Single-bit moves walk the path either way; only CW3/CCW3 -> rest counts a detent
    always_comb begin
        state_next = state;
        step_cw    = 1'b0;
        step_ccw   = 1'b0;
        err        = 1'b0;
        if (state != ST_IDLE_WAIT && (ab ^ state_code(state)) == 2'b11) begin
            err        = 1'b1;
            state_next = fresh_state(ab);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ab == PH1_CW)       state_next = ST_CW1;
                    else if (ab == PH1_CCW) state_next = ST_CCW1;
                end
                ST_CW1: begin
                    if (ab == PH_MID)       state_next = ST_CW2;
                    else if (ab == REST)    state_next = ST_IDLE;
                end
                ST_CW2: begin
                    if (ab == PH1_CCW)      state_next = ST_CW3;
                    else if (ab == PH1_CW)  state_next = ST_CW1;
                end
                ST_CW3: begin
                    if (ab == REST) begin
                        state_next = ST_IDLE;
                        step_cw    = 1'b1;
                    end else if (ab == PH_MID) begin
                        state_next = ST_CW2;
                    end
                end
                ST_CCW1: begin
                    if (ab == PH_MID)       state_next = ST_CCW2;
                    else if (ab == REST)    state_next = ST_IDLE;
                end
                ST_CCW2: begin
                    if (ab == PH1_CW)       state_next = ST_CCW3;
                    else if (ab == PH1_CCW) state_next = ST_CCW1;
                end
                ST_CCW3: begin
                    if (ab == REST) begin
                        state_next = ST_IDLE;
                        step_ccw   = 1'b1;
                    end else if (ab == PH_MID) begin
                        state_next = ST_CCW2;
                    end
                end
                default: begin
                    if (ab != PH_MID) state_next = fresh_state(ab);
                end
            endcase
        end
    end

    // Clear overrides the count, but the step pulse and direction still report the step
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q        <= '0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= DIR_CCW;
            btn_prev     <= 1'b0;
            btn_pulse_q  <= 1'b0;
            quad_err_q   <= 1'b0;
        end else begin
            if (bus.pos_clear)  pos_q <= '0;
            else if (step_cw)   pos_q <= pos_q + POS_W'(1);
            else if (step_ccw)  pos_q <= pos_q - POS_W'(1);
            step_pulse_q <= step_cw | step_ccw;
            if (step_cw | step_ccw) step_dir_q <= step_cw ? DIR_CW : DIR_CCW;
            btn_prev    <= deb_btn;
            btn_pulse_q <= deb_btn & ~btn_prev;
            quad_err_q  <= err;
        end
    end

    assign bus.position   = pos_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.btn_level  = deb_btn;
    assign bus.swt_level  = deb_swt;
    assign bus.btn_pulse  = btn_pulse_q;
    assign bus.quad_err   = quad_err_q;

`ifdef ENC_VELOCITY_EN
    localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
    localparam logic signed [POS_W-1:0] VEL_MAX = {1'b0, {(POS_W-1){1'b1}}};

    logic [WIN_W-1:0]        win_cnt;
    logic signed [POS_W-1:0] acc, acc_next, vel_q;

    always_comb begin
        acc_next = acc;
        if (step_cw && acc != VEL_MAX)        acc_next = acc + POS_W'(1);
        else if (step_ccw && acc != -VEL_MAX) acc_next = acc - POS_W'(1);
    end

    // A step on the last window cycle is folded into the value being latched
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
            acc     <= '0;
            vel_q   <= '0;
        end else if (win_cnt == WIN_W'(VEL_WINDOW - 1)) begin
            win_cnt <= '0;
            acc     <= '0;
            vel_q   <= acc_next;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            acc     <= acc_next;
        end
    end

    assign bus.velocity = vel_q;
`endif

endmodule

// File: tb/tb_rotary_enc_decoder.sv
// Self-checking bench for rotary_enc_decoder: directed scenarios plus a random
// walk of A/B codes against a phase-progress reference model.
module tb_rotary_enc_decoder;

    localparam int DEB = 4;
    localparam int PW  = 8;
    localparam int VW  = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rotary_enc_decoder_if #(.POS_W(PW)) bus ();

    rotary_enc_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .POS_W(PW)
`ifdef ENC_VELOCITY_EN
        , .VEL_WINDOW(VW)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int check_count = 0;
    int error_count = 0;

    int mon_steps = 0;
    int mon_errs  = 0;
    int mon_btn   = 0;

    logic [PW-1:0] exp_pos;
    logic          exp_dir;
    int            exp_steps, exp_errs, exp_btn;
    int            prog;
    bit            waitf;
    logic [1:0]    cur_code;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.step_pulse) mon_steps++;
            if (bus.quad_err)   mon_errs++;
            if (bus.btn_pulse)  mon_btn++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int gidx(input logic [1:0] c);
        case (c)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    // Progress model: net quarter-turns since leaving rest, +-4 on return to rest is a detent
    task automatic modelCode(input logic [1:0] c);
        int d;
        if (c == cur_code) return;
        d = (gidx(c) - gidx(cur_code) + 4) % 4;
        if (waitf) begin
            prog  = (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
            waitf = 1'b0;
        end else if (d == 2) begin
            exp_errs++;
            waitf = (c == 2'b00);
            prog  = (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
        end else begin
            prog += (d == 1) ? 1 : -1;
            if (c == 2'b11) begin
                if (prog == 4) begin
                    exp_pos = exp_pos + 1'b1;
                    exp_dir = 1'b1;
                    exp_steps++;
                end else if (prog == -4) begin
                    exp_pos = exp_pos - 1'b1;
                    exp_dir = 1'b0;
                    exp_steps++;
                end
                prog = 0;
            end
        end
        cur_code = c;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c, input int hold);
        bus.encA = c[1];
        bus.encB = c[0];
        modelCode(c);
        tick(hold);
    endtask

    task automatic cwStep(input int hold);
        applyStimulus(2'b01, hold);
        applyStimulus(2'b00, hold);
        applyStimulus(2'b10, hold);
        applyStimulus(2'b11, hold);
    endtask

    task automatic ccwStep(input int hold);
        applyStimulus(2'b10, hold);
        applyStimulus(2'b00, hold);
        applyStimulus(2'b01, hold);
        applyStimulus(2'b11, hold);
    endtask

    task automatic clearPos();
        bus.pos_clear = 1'b1;
        tick(1);
        bus.pos_clear = 1'b0;
        exp_pos = '0;
    endtask

    task automatic doReset();
        bus.encA = 1'b1;
        bus.encB = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        exp_pos  = '0;
        exp_dir  = 1'b0;
        prog     = 0;
        waitf    = 1'b0;
        cur_code = 2'b11;
    endtask

    function automatic logic [31:0] posVal();
        return {{(32-PW){1'b0}}, bus.position};
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, "_pos"}, posVal(), 32'(exp_pos));
        checkOutput({tag, "_dir"}, 32'(bus.step_dir), 32'(exp_dir));
        checkOutput({tag, "_steps"}, mon_steps, exp_steps);
        checkOutput({tag, "_errs"}, mon_errs, exp_errs);
    endtask

    initial begin
        int lat;
        logic [1:0] nc, m;
        exp_steps = 0;
        exp_errs  = 0;
        exp_btn   = 0;
        bus.encBTN    = 1'b1;
        bus.encSWT    = 1'b1;
        bus.pos_clear = 1'b0;
        doReset();

        checkOutput("rst_pos", posVal(), 32'h0);
        checkOutput("rst_step_pulse", 32'(bus.step_pulse), 32'h0);
        checkOutput("rst_step_dir", 32'(bus.step_dir), 32'h0);
        checkOutput("rst_btn_level", 32'(bus.btn_level), 32'h0);
        checkOutput("rst_swt_level", 32'(bus.swt_level), 32'h0);
        checkOutput("rst_btn_pulse", 32'(bus.btn_pulse), 32'h0);
        checkOutput("rst_quad_err", 32'(bus.quad_err), 32'h0);
        tick(1);
        bus.encBTN = 1'b0;
        bus.encSWT = 1'b0;
        tick(20);
        checkOutput("idle_steps", mon_steps, 0);
        checkOutput("idle_errs", mon_errs, 0);
        checkOutput("idle_btn", mon_btn, 0);
        checkOutput("idle_btn_level", 32'(bus.btn_level), 32'h0);

        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b10, 10);
        bus.encA = 1'b1;
        bus.encB = 1'b1;
        modelCode(2'b11);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (bus.step_pulse && lat == 0) lat = k;
        end
        checkOutput("cw_latency", lat, 7);
        checkState("cw1");
        checkOutput("cw1_pos_abs", posVal(), 32'h1);

        clearPos();
        for (int i = 0; i < 6; i++) begin
            bus.encA = ~bus.encA;
            tick(2);
        end
        tick(10);
        checkState("bounce");
        ccwStep(10);
        checkState("ccw1");
        checkOutput("ccw1_pos_abs", posVal(), 32'hFF);

        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        checkState("partial");

        applyStimulus(2'b00, 10);
        checkOutput("illegal_errs", mon_errs, exp_errs);
        applyStimulus(2'b11, 10);
        checkState("illegal_ret");

        clearPos();
        repeat (127) cwStep(5);
        tick(4);
        checkState("preload");
        checkOutput("preload_abs", posVal(), 32'h7F);
        cwStep(8);
        checkOutput("wrap_up", posVal(), 32'h80);
        ccwStep(8);
        checkOutput("wrap_down", posVal(), 32'h7F);
        cwStep(8);
        checkState("wrap_back");

        applyStimulus(2'b10, 8);
        applyStimulus(2'b00, 8);
        applyStimulus(2'b01, 8);
        bus.encA = 1'b1;
        bus.encB = 1'b1;
        modelCode(2'b11);
        tick(6);
        bus.pos_clear = 1'b1;
        tick(1);
        bus.pos_clear = 1'b0;
        exp_pos = '0;
        checkOutput("clr_step_pulse", 32'(bus.step_pulse), 32'h1);
        checkOutput("clr_pos", posVal(), 32'h0);
        checkOutput("clr_dir", 32'(bus.step_dir), 32'h0);
        tick(5);

        bus.encBTN = 1'b1;
        tick(10);
        exp_btn++;
        checkOutput("btn_level_hi", 32'(bus.btn_level), 32'h1);
        checkOutput("btn_pulses", mon_btn, exp_btn);
        bus.encSWT = 1'b1;
        tick(10);
        checkOutput("swt_level_hi", 32'(bus.swt_level), 32'h1);
        bus.encBTN = 1'b0;
        tick(10);
        checkOutput("btn_level_lo", 32'(bus.btn_level), 32'h0);
        bus.encSWT = 1'b0;
        tick(10);
        checkOutput("swt_level_lo", 32'(bus.swt_level), 32'h0);
        bus.encBTN = 1'b1;
        tick(2);
        bus.encBTN = 1'b0;
        tick(10);
        checkOutput("btn_glitch_level", 32'(bus.btn_level), 32'h0);
        checkOutput("btn_pulses_end", mon_btn, exp_btn);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            m = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            if (r < 7) begin
                nc = cur_code ^ m;
                applyStimulus(nc, $urandom_range(8, 12));
            end else if (r < 8) begin
                nc = ~cur_code;
                applyStimulus(nc, $urandom_range(8, 12));
            end else begin
                nc = cur_code ^ m;
                bus.encA = nc[1];
                bus.encB = nc[0];
                tick($urandom_range(1, DEB - 1));
                bus.encA = cur_code[1];
                bus.encB = cur_code[0];
                tick(8);
            end
            checkOutput("rand_pos", posVal(), 32'(exp_pos));
        end
        checkState("rand_end");

        applyStimulus(2'b11, 10);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b10, 10);
        doReset();
        tick(20);
        checkState("mid_reset");

`ifdef ENC_VELOCITY_EN
        doReset();
        cwStep(5);
        cwStep(5);
        cwStep(5);
        tick(45);
        checkOutput("velocity_3", 32'(bus.velocity), 32'd3);
        tick(100);
        checkOutput("velocity_0", 32'(bus.velocity), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
